// File: rtl/parity_rx_pkg.sv
// Shared parity constants: FSM state encoding and even/odd selectors.
package parity_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int PAR_EVEN = 0;
  localparam int PAR_ODD  = 1;

endpackage

// File: rtl/parity_rx_xor2.sv
// Two-input XOR cell used for the running-parity update.
module parity_rx_xor2 (
  input  logic a,
  input  logic b,
  output logic y
);

  assign y = a ^ b;

endmodule

// File: rtl/parity_rx.sv
// Serial frame receiver: N data bits LSB first, then one parity bit.
// Reports the data word and a parity error flag with a one-cycle done pulse.
module parity_rx
  import parity_rx_pkg::*;
#(
  parameter int N   = 8,
  parameter int ODD = PAR_EVEN
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         bit_in,
  input  logic         bit_valid,
  output logic [N-1:0] data_out,
  output logic         parity_err,
  output logic         done,
  output logic         busy
);

  localparam int             CW      = $clog2(N + 1);
  localparam logic [CW-1:0]  LAST    = CW'(N - 1);
  localparam logic           ODD_BIT = (ODD == PAR_ODD);

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [N-1:0]  shreg;
  logic          run_par;
  logic          par_x;
  logic          clr;
  logic          take_data;
  logic          take_par;

  // In DATA this is the next running parity; in PARITY it is the raw check.
  parity_rx_xor2 u_xor (
    .a (run_par),
    .b (bit_in),
    .y (par_x)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    clr       = 1'b0;
    take_data = 1'b0;
    take_par  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = DATA;
          clr     = 1'b1;
        end
      end
      DATA: begin
        if (bit_valid) begin
          take_data = 1'b1;
          if (cnt == LAST) state_n = PARITY;
        end
      end
      PARITY: begin
        if (bit_valid) begin
          take_par = 1'b1;
          state_n  = DONE;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      shreg   <= '0;
      run_par <= 1'b0;
    end else if (clr) begin
      cnt     <= '0;
      shreg   <= '0;
      run_par <= 1'b0;
    end else if (take_data) begin
      shreg   <= {bit_in, shreg[N-1:1]};
      run_par <= par_x;
      cnt     <= cnt + CW'(1);
    end
  end

  // Results land on the edge that enters DONE and hold until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      parity_err <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      done <= take_par;
      busy <= (state_n != IDLE);
      if (take_par) begin
        data_out   <= shreg;
        parity_err <= par_x ^ ODD_BIT;
      end
    end
  end

endmodule
